// File: rtl/mmio_uart_tx_pkg.sv
// uart_pkg: definitions shared by the memory-mapped UART transmitter.
//   - register offsets, decoded from ALUResult[3:2]
//   - bit positions of the STATUS register
//   - serializer state encoding
package uart_pkg;

  // Register offsets (word index inside the 16-byte window)
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  // STATUS bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: store/load port between the core's data-memory side and
// the UART register window.
//   MemWrite  - store strobe
//   ALUResult - byte address
//   WriteData - store data
//   Hit       - address falls inside the UART window (combinational)
//   ReadData  - load data, 0 outside the window (combinational)
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        Hit;
  logic [31:0] ReadData;

  modport master (
    output MemWrite, ALUResult, WriteData,
    input  Hit, ReadData
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData,
    output Hit, ReadData
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read.
//   clk, reset - clock, asynchronous active-high reset (flushes contents)
//   push, din  - write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop, dout  - read request and current head entry
//   full, empty, count - occupancy, count is log2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             wr_en, rd_en;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // When full, the slot under wr_ptr is the one being popped, so a
  // simultaneous push can reuse it.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - core store/load port (slave side); Hit/ReadData combinational
//   tx         - serial line, idles high
//   tx_busy    - serializer active or bytes still queued
// Registers: 0x0 TXDATA (push), 0x4 STATUS, 0x8 DIV, 0xC reserved.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic            clk,
  input  logic            reset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx,
  output logic            tx_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic           hit, reg_wr, push_req;
  logic [1:0]     reg_sel;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           ovf_reg;
  logic [15:0]    div_reg;
  logic [31:0]    status_word, rdata;

  uart_tx_state_t state_reg, state_next;
  logic [7:0]     shift_reg, shift_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [15:0]    baud_cnt_reg, baud_cnt_next;
  logic           tx_reg, tx_next;
  logic           bit_end;

  // Address decode: low two address bits are don't-care.
  assign hit      = (bus.ALUResult[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = bus.ALUResult[3:2];
  assign reg_wr   = bus.MemWrite && hit;
  assign push_req = reg_wr && (reg_sel == UART_TXDATA);

  logic unused_bits;
  assign unused_bits = ^{bus.ALUResult[1:0], bus.WriteData[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (bus.WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow is sticky: only a rejected push sets it, only STATUS bit3 clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
      div_reg <= DEFAULT_DIV;
    end else begin
      if (push_req && fifo_full && !fifo_pop)
        ovf_reg <= 1'b1;
      else if (reg_wr && reg_sel == UART_STATUS && bus.WriteData[ST_OVF])
        ovf_reg <= 1'b0;
      // A zero divisor would never end a bit, so it is clamped to 1.
      if (reg_wr && reg_sel == UART_DIV)
        div_reg <= (bus.WriteData[15:0] == 16'd0) ? 16'd1 : bus.WriteData[15:0];
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = (state_reg != IDLE);
    status_word[ST_OVF]   = ovf_reg;
    status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        UART_STATUS: rdata = status_word;
        UART_DIV:    rdata = {16'b0, div_reg};
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.Hit      = hit;
  assign bus.ReadData = rdata;

  // '>=' rather than '==' so a divisor lowered mid-bit below the current
  // count still ends the bit on the next cycle.
  assign bit_end = (baud_cnt_reg >= div_reg - 16'd1);

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    baud_cnt_next = baud_cnt_reg + 16'd1;
    fifo_pop      = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          bit_cnt_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          // Chain straight into the next frame when more data is queued.
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            shift_next   = fifo_dout;
            bit_cnt_next = '0;
            state_next   = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Line level is registered from the next state so tx is glitch-free.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      baud_cnt_reg <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      baud_cnt_reg <= baud_cnt_next;
      tx_reg       <= tx_next;
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE) || !fifo_empty;
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the data-memory side of the single-cycle core. It consumes the core's store interface (MemWrite, ALUResult as address, WriteData) and returns load data combinationally in the same cycle. Written bytes go through a small FIFO and are serialized as 8N1, LSB first, at a programmable baud divisor. The top-level read mux selects this block's load data over data memory whenever Hit is high.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; bits [3:0] must be 0
FIFO_DEPTH, 8, number of TX FIFO entries; power of two, at least 2
DEFAULT_DIV, 16'd868, baud divisor after reset (clk cycles per bit)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  store strobe from core
ALUResult  input  32  byte address from core
WriteData  input  32  store data from core
Hit  output  1  ALUResult[31:4] == BASE_ADDR[31:4]; combinational
ReadData  output  32  register read data; combinational; 0 when Hit=0
tx  output  1  serial line, idles high
tx_busy  output  1  high when the serializer is not IDLE or the FIFO is non-empty

Behaviour:
- Decode uses ALUResult[3:2]; ALUResult[1:0] is ignored.
- Offset 0x0, TXDATA:
  - Write pushes WriteData[7:0].
  - Reads return 0.
- Offset 0x4, STATUS (read):
  - bit0 full, bit1 empty, bit2 serializer busy, bit3 overflow (sticky).
  - bits[11:8] entry count, zero-extended; all other bits 0.
- STATUS write: WriteData[3]=1 clears overflow; all other bits are ignored.
- Offset 0x8, DIV:
  - Reads return {16'b0, div}.
  - A write loads WriteData[15:0]; a value of 0 is stored as 1.
- Offset 0xC: reserved; reads 0, writes ignored.
- Register writes take effect on the clk edge where MemWrite && Hit.
- Reset values: tx=1, tx_busy=0, FIFO empty, count=0, overflow=0, div=DEFAULT_DIV, state IDLE, bit counter 0, baud counter 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame, drives tx=1 immediately and flushes the FIFO.
- Push when full: byte dropped, overflow set, FIFO unchanged.
  - A push coinciding with a pop while full is accepted; count stays at FIFO_DEPTH.
- Push and pop in the same cycle when not full: count unchanged.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop into the shift register and go to START next cycle. The byte is not popped in the same cycle it is pushed, so first-byte latency is one cycle after the push edge.
  - START: tx=0 for div cycles.
  - DATA: shift out 8 bits, LSB first, div cycles each. A bit counter 0..7 advances when the baud counter reaches div-1.
  - STOP: tx=1 for div cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter: 16 bits, cleared on every state/bit transition. The bit ends when the counter reaches div-1.
- A DIV write mid-frame applies from the next bit boundary. If the counter already exceeds the new div-1, the bit ends on the next cycle.
- Frame length is exactly 10*div cycles.

Decomposition:
- Shared package uart_pkg:
  - register offset constants (UART_TXDATA=2'd0, UART_STATUS=2'd1, UART_DIV=2'd2)
  - STATUS bit-index constants
  - FSM state enum uart_tx_state_t (IDLE, START, DATA, STOP)
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; outputs full, empty, count), instantiated with WIDTH=8, DEPTH=FIFO_DEPTH.
- Serializer, decode and registers stay in mmio_uart_tx.

Test Plan:
1. Reset, then read 0x1000_0004 and 0x1000_0008 -> ReadData=32'h0000_0002 and 32'h0000_0364; tx=1.
2. Write DIV=4, then write 0x55 to TXDATA -> tx low from cycle push+2 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Frame is 40 cycles; tx_busy drops after the stop bit.
3. DIV=4, push 9 bytes in consecutive cycles -> first byte popped by the serializer. STATUS then shows count=8, full=1, overflow=0. A 10th push sets overflow=1 and the byte is lost.
4. With overflow set, write STATUS with 32'h8 -> overflow=0. Frames are transmitted back-to-back with no idle cycle between stop and start.
5. Write DIV=0 -> DIV reads 1 and the frame is 10 cycles. Access 0x1000_0010 -> Hit=0, ReadData=0, no state change.
6. Assert reset in the middle of DATA -> tx=1 in the same cycle (asynchronous). After release: FIFO empty, count=0, tx_busy=0, STATUS=32'h2.
